lsu_mem_ctrl: RTL and testbench
===============================

# lsu_mem_ctrl

Load/store memory-access controller sitting directly downstream of the address generation unit in the execute stage. It accepts one lane-aligned memory operation at a time from the AGU and runs a request/grant/response transaction on the RIB data bus. For loads, it extracts and extends the addressed byte or halfword and issues a one-cycle register write-back. It holds the pipeline via `busy_o` while a transaction is outstanding.

## Interface
- `ADDR_W`, 32, bus address width
- `DATA_W`, 32, bus data width (fixed 32; byte lanes = 4)
- `RADDR_W`, 5, register address width
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `op_valid_i` in 1: AGU presents an operation
- `op_ready_o` out 1: operation accepted this cycle when high with `op_valid_i`
- `op_we_i` in 1: 1 = store, 0 = load
- `op_addr_i` in ADDR_W: effective byte address
- `op_wdata_i` in DATA_W: store data, already shifted to its byte lanes
- `op_wmask_i` in 4: store byte-lane mask
- `op_funct3_i` in 3: RISC-V funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- `op_rd_i` in RADDR_W: load destination register
- `flush_i` in 1: interrupt/flush; cancels ungranted work
- `bus_req_o` out 1: bus request
- `bus_gnt_i` in 1: bus grant; the transfer is issued in the cycle where `bus_req_o` and `bus_gnt_i` are both high
- `bus_addr_o` out ADDR_W: word-aligned address (bits [1:0] = 0)
- `bus_we_o` out 1, `bus_wdata_o` out DATA_W, `bus_wmask_o` out 4: write controls
- `bus_rvalid_i` in 1: response/ack for the issued transfer (loads and stores)
- `bus_rdata_i` in DATA_W: read data, valid with `bus_rvalid_i`
- `reg_we_o` out 1, `reg_waddr_o` out RADDR_W, `reg_wdata_o` out 32: load write-back
- `busy_o` out 1: high in any state other than IDLE
- `misalign_o` out 1: one-cycle pulse on a rejected misaligned access

## Operation
- **States:** IDLE, REQ, WAIT.
- **`op_ready_o`:** equals `(state==IDLE) && !flush_i`. It is combinational.
- **Accept (IDLE, `op_valid_i && op_ready_o`):** capture all `op_*` fields, including `addr[1:0]`.
- **Misalignment check:**
  - Halfword (funct3[1:0]=01) with addr[0]=1 is misaligned.
  - Word (funct3[1:0]=10) with addr[1:0]≠0 is misaligned.
  - On a misaligned access: pulse `misalign_o` in the next cycle, stay in IDLE, and issue no bus activity.
  - Otherwise go to REQ.
- **REQ:**
  - Drive `bus_req_o`=1 with the registered address/controls.
  - Hold all bus outputs stable until grant.
  - On grant, go to WAIT.
  - On `flush_i` without grant, drop the request and return to IDLE.
  - If `flush_i` and grant occur in the same cycle, the grant wins: go to WAIT and set the discard flag.
- **WAIT:**
  - `bus_req_o`=0.
  - `flush_i` sets the discard flag; the transfer is never cancelled.
  - On `bus_rvalid_i`:
    - Stores complete.
    - Loads latch the extracted data.
    - Return to IDLE.
- **Load write-back:** `reg_we_o` pulses for one cycle after `bus_rvalid_i`, but only if the operation is a load, the discard flag is clear, and rd≠0.
- **Load extraction** (lane selected by captured addr[1:0]):
  - LB/LBU: byte lane addr[1:0]; sign-extend from bit 7, or zero-extend.
  - LH/LHU: lanes [15:0] if addr[1]=0, else [31:16]; sign-extend or zero-extend.
  - LW: whole word.
  - Undefined funct3 produces 0.
- **Store:** `bus_wdata_o`/`bus_wmask_o` pass the captured AGU values unchanged. An undefined funct3 forces the mask to 4'b0000; the transfer still occurs.
- **Reset (async, while `rst`=1):**
  - State IDLE; discard flag cleared.
  - `bus_req_o`, `bus_we_o`, `reg_we_o`, `misalign_o`, `busy_o` = 0.
  - `bus_addr_o`, `bus_wdata_o`, `bus_wmask_o`, `reg_waddr_o`, `reg_wdata_o` = 0.
  - Reset mid-transaction abandons it. Any late `bus_rvalid_i` seen in IDLE is ignored.

## Timing
- **Load, zero-wait bus** (accept at T, grant at T+1, rvalid at T+2): `bus_req_o` high in T+1; `reg_we_o` high in T+3; `op_ready_o` high again from T+3.
- **Store, same bus timing:** `busy_o` is high T+1..T+2; next accept at T+3.
- **Throughput:** one operation per 3 cycles minimum; each extra grant or response wait adds one cycle.
- **Misaligned:** `misalign_o` high in T+1; next accept possible at T+1.
- **Registered outputs:** `reg_we_o` and `misalign_o` are registered single-cycle pulses. All bus outputs are registered.
- **`bus_rvalid_i` outside WAIT** is ignored.

## Test plan
- **LB, addr 0x1003:** rdata 0x80FF_1234 → `bus_addr_o`=0x1000, `reg_wdata_o`=0xFFFF_FF80, `reg_we_o` for one cycle with rd=5.
- **LHU, addr 0x2002:** rdata 0xBEEF_0001 → `reg_wdata_o`=0x0000_BEEF. A second case with grant held low for 3 cycles must show `bus_req_o` and `bus_addr_o` stable throughout.
- **SB, addr 0x13:** wdata 0xAB00_0000, mask 4'b1000 → `bus_we_o`=1, address 0x10, mask 4'b1000; no `reg_we_o`; `busy_o` drops after rvalid.
- **LW, addr 0x102:** `misalign_o` pulse in T+1; no `bus_req_o`; `op_ready_o` stays high.
- **Flush timing:**
  - `flush_i` in REQ before grant → `bus_req_o` drops next cycle, state IDLE, no write-back.
  - `flush_i` together with grant → transfer completes, no `reg_we_o`.
- **Edge cases:**
  - Load with rd=0 → no `reg_we_o`.
  - `rst` asserted in WAIT → all outputs 0 immediately; a following stray `bus_rvalid_i` produces no write-back.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : Load/store controller: one AGU operation at a time over the RIB
//            request/grant/response bus, with load extraction and write-back.
// Revision : 1.0 - initial release
// ============================================================================

module lsu_mem_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               op_valid_i,
    output logic               op_ready_o,
    input  logic               op_we_i,
    input  logic [ADDR_W-1:0]  op_addr_i,
    input  logic [DATA_W-1:0]  op_wdata_i,
    input  logic [3:0]         op_wmask_i,
    input  logic [2:0]         op_funct3_i,
    input  logic [RADDR_W-1:0] op_rd_i,
    input  logic               flush_i,
    output logic               bus_req_o,
    input  logic               bus_gnt_i,
    output logic [ADDR_W-1:0]  bus_addr_o,
    output logic               bus_we_o,
    output logic [DATA_W-1:0]  bus_wdata_o,
    output logic [3:0]         bus_wmask_o,
    input  logic               bus_rvalid_i,
    input  logic [DATA_W-1:0]  bus_rdata_i,
    output logic               reg_we_o,
    output logic [RADDR_W-1:0] reg_waddr_o,
    output logic [31:0]        reg_wdata_o,
    output logic               busy_o,
    output logic               misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t               r_state;
    logic [2:0]           r_funct3;
    logic [1:0]           r_lane;
    logic [RADDR_W-1:0]   r_rd;
    logic                 r_discard;

    logic                 w_accept;
    logic                 w_misalign;
    logic                 w_store_ok;
    logic [7:0]           w_byte;
    logic [15:0]          w_half;
    logic [31:0]          w_load_data;

    assign op_ready_o = (r_state == S_IDLE) && !flush_i;
    assign busy_o     = (r_state != S_IDLE);
    assign w_accept   = op_valid_i && op_ready_o;

    assign w_misalign = ((op_funct3_i[1:0] == 2'b01) && op_addr_i[0]) ||
                        ((op_funct3_i[1:0] == 2'b10) && (op_addr_i[1:0] != 2'b00));
    assign w_store_ok = (op_funct3_i == 3'b000) || (op_funct3_i == 3'b001) ||
                        (op_funct3_i == 3'b010);

    always_comb begin
        w_byte = 8'h00;
        case (r_lane)
            2'd0:    w_byte = bus_rdata_i[7:0];
            2'd1:    w_byte = bus_rdata_i[15:8];
            2'd2:    w_byte = bus_rdata_i[23:16];
            default: w_byte = bus_rdata_i[31:24];
        endcase
    end

    assign w_half = r_lane[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

    always_comb begin
        w_load_data = 32'h0;
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_load_data = {24'h0, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b101:  w_load_data = {16'h0, w_half};
            3'b010:  w_load_data = bus_rdata_i;
            default: w_load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_funct3    <= 3'b000;
            r_lane      <= 2'b00;
            r_rd        <= '0;
            r_discard   <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_addr_o  <= '0;
            bus_we_o    <= 1'b0;
            bus_wdata_o <= '0;
            bus_wmask_o <= 4'b0000;
            reg_we_o    <= 1'b0;
            reg_waddr_o <= '0;
            reg_wdata_o <= 32'h0;
            misalign_o  <= 1'b0;
        end else begin
            reg_we_o   <= 1'b0;
            misalign_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= op_funct3_i;
                        r_lane    <= op_addr_i[1:0];
                        r_rd      <= op_rd_i;
                        r_discard <= 1'b0;
                        if (w_misalign) begin
                            misalign_o <= 1'b1;
                        end else begin
                            r_state     <= S_REQ;
                            bus_req_o   <= 1'b1;
                            bus_addr_o  <= {op_addr_i[ADDR_W-1:2], 2'b00};
                            bus_we_o    <= op_we_i;
                            bus_wdata_o <= op_wdata_i;
                            bus_wmask_o <= w_store_ok ? op_wmask_i : 4'b0000;
                        end
                    end
                end
                S_REQ: begin
                    // A grant coinciding with flush still issues the transfer.
                    if (bus_gnt_i) begin
                        r_state   <= S_WAIT;
                        bus_req_o <= 1'b0;
                        if (flush_i) r_discard <= 1'b1;
                    end else if (flush_i) begin
                        r_state   <= S_IDLE;
                        bus_req_o <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (flush_i) r_discard <= 1'b1;
                    if (bus_rvalid_i) begin
                        r_state <= S_IDLE;
                        if (!bus_we_o) begin
                            reg_waddr_o <= r_rd;
                            reg_wdata_o <= w_load_data;
                            reg_we_o    <= !r_discard && !flush_i && (r_rd != '0);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Brief    : Directed and randomized transactions against a reference model.
// Revision : 1.0 - initial release
// ============================================================================

module tb_lsu_mem_ctrl;

    logic        clk;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic        op_we;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic [3:0]  op_wmask;
    logic [2:0]  op_funct3;
    logic [4:0]  op_rd;
    logic        flush;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        busy;
    logic        misalign;

    int n_cmp = 0;
    int n_err = 0;

    lsu_mem_ctrl #(.ADDR_W(32), .DATA_W(32), .RADDR_W(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .op_valid_i   (op_valid),
        .op_ready_o   (op_ready),
        .op_we_i      (op_we),
        .op_addr_i    (op_addr),
        .op_wdata_i   (op_wdata),
        .op_wmask_i   (op_wmask),
        .op_funct3_i  (op_funct3),
        .op_rd_i      (op_rd),
        .flush_i      (flush),
        .bus_req_o    (bus_req),
        .bus_gnt_i    (bus_gnt),
        .bus_addr_o   (bus_addr),
        .bus_we_o     (bus_we),
        .bus_wdata_o  (bus_wdata),
        .bus_wmask_o  (bus_wmask),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .reg_we_o     (reg_we),
        .reg_waddr_o  (reg_waddr),
        .reg_wdata_o  (reg_wdata),
        .busy_o       (busy),
        .misalign_o   (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference load result from the architectural rules.
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] lane,
                                               input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * lane)) & 32'hFF;
        h = lane[1] ? (d >> 16) : (d & 32'hFFFF);
        case (f3)
            3'b000:  return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'b101:  return h;
            3'b010:  return d;
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_all_zero(input string pfx);
        chk({pfx, "_req"},    {31'h0, bus_req},  32'h0);
        chk({pfx, "_we"},     {31'h0, bus_we},   32'h0);
        chk({pfx, "_addr"},   bus_addr,          32'h0);
        chk({pfx, "_wdata"},  bus_wdata,         32'h0);
        chk({pfx, "_wmask"},  {28'h0, bus_wmask}, 32'h0);
        chk({pfx, "_regwe"},  {31'h0, reg_we},   32'h0);
        chk({pfx, "_waddr"},  {27'h0, reg_waddr}, 32'h0);
        chk({pfx, "_rwdata"}, reg_wdata,         32'h0);
        chk({pfx, "_busy"},   {31'h0, busy},     32'h0);
        chk({pfx, "_mis"},    {31'h0, misalign}, 32'h0);
    endtask

    // fm: 0 none, 1 flush in REQ before grant, 2 flush with grant, 3 flush in WAIT
    task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] mask, input logic [4:0] rd,
                         input int gw_in, input int rw, input int fm_in, input logic [31:0] rdata);
        logic        mis;
        logic        disc;
        logic        exp_we;
        logic [31:0] exp_mask;
        int          fat;
        int          gw;
        int          fm;
        gw  = gw_in;
        fm  = fm_in;
        mis = ((f3 == 3'b001 || f3 == 3'b101) && addr[0]) ||
              ((f3 == 3'b010 || f3 == 3'b110) && addr[1:0] != 2'b00);
        exp_mask = (f3 <= 3'b010) ? {28'h0, mask} : 32'h0;

        op_valid = 1'b1; op_we = we; op_addr = addr; op_wdata = wdata;
        op_wmask = mask; op_funct3 = f3; op_rd = rd;
        flush = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1;
        chk("ready_idle", {31'h0, op_ready}, 32'h1);
        step();
        op_valid = 1'b0; op_addr = $urandom; op_wdata = $urandom;
        op_wmask = 4'($urandom); op_funct3 = 3'($urandom); op_rd = 5'($urandom); op_we = 1'($urandom);
        if (mis) begin
            chk("mis_pulse", {31'h0, misalign}, 32'h1);
            chk("mis_noreq", {31'h0, bus_req},  32'h0);
            chk("mis_busy",  {31'h0, busy},     32'h0);
            chk("mis_ready", {31'h0, op_ready}, 32'h1);
            step();
            chk("mis_once",  {31'h0, misalign}, 32'h0);
            return;
        end
        chk("no_mis", {31'h0, misalign}, 32'h0);
        if (fm == 1 && gw == 0) fm = 0;
        if (fm == 3 && rw == 0) fm = 0;
        fat = (fm == 1) ? $urandom_range(0, gw - 1) : 0;

        for (int k = 0; k <= gw; k++) begin
            chk("req_hi",   {31'h0, bus_req}, 32'h1);
            chk("req_busy", {31'h0, busy},    32'h1);
            chk("req_addr", bus_addr, addr & 32'hFFFF_FFFC);
            chk("req_we",   {31'h0, bus_we},  {31'h0, we});
            if (we) begin
                chk("req_wdata", bus_wdata, wdata);
                chk("req_wmask", {28'h0, bus_wmask}, exp_mask);
            end
            bus_gnt = (k == gw) && !(fm == 1 && k == fat);
            flush   = (fm == 1 && k == fat) || (fm == 2 && k == gw);
            #1;
            chk("req_notready", {31'h0, op_ready}, 32'h0);
            step();
            bus_gnt = 1'b0;
            if (fm == 1 && k == fat) begin
                flush = 1'b0;
                #1;
                chk("flush_req_drop", {31'h0, bus_req}, 32'h0);
                chk("flush_idle",     {31'h0, busy},    32'h0);
                chk("flush_ready",    {31'h0, op_ready}, 32'h1);
                chk("flush_nowb",     {31'h0, reg_we},  32'h0);
                return;
            end
            flush = 1'b0;
            if (k == gw) break;
        end

        for (int j = 0; j <= rw; j++) begin
            chk("wait_noreq", {31'h0, bus_req}, 32'h0);
            chk("wait_busy",  {31'h0, busy},    32'h1);
            chk("wait_nowe",  {31'h0, reg_we},  32'h0);
            bus_rvalid = (j == rw);
            bus_rdata  = (j == rw) ? rdata : $urandom;
            flush      = (fm == 3 && j == 0);
            #1;
            chk("wait_notready", {31'h0, op_ready}, 32'h0);
            step();
            bus_rvalid = 1'b0;
            flush      = 1'b0;
        end

        disc   = (fm == 2) || (fm == 3);
        exp_we = !we && !disc && (rd != 5'd0);
        #1;
        chk("done_busy",  {31'h0, busy},     32'h0);
        chk("done_ready", {31'h0, op_ready}, 32'h1);
        chk("done_mis",   {31'h0, misalign}, 32'h0);
        chk("wb_we",      {31'h0, reg_we},   {31'h0, exp_we});
        if (exp_we) begin
            chk("wb_addr", {27'h0, reg_waddr}, {27'h0, rd});
            chk("wb_data", reg_wdata, model_load(f3, addr[1:0], rdata));
        end
        // A stray response in IDLE must not produce another write-back.
        bus_rvalid = 1'($urandom);
        bus_rdata  = $urandom;
        step();
        bus_rvalid = 1'b0;
        chk("wb_pulse", {31'h0, reg_we}, 32'h0);
        chk("stray_idle", {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int r;
        int fm;
        rst = 1'b1; op_valid = 1'b0; op_we = 1'b0; op_addr = 32'h0; op_wdata = 32'h0;
        op_wmask = 4'h0; op_funct3 = 3'h0; op_rd = 5'h0; flush = 1'b0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        #2;
        chk_all_zero("rst");
        step(); step();
        rst = 1'b0;
        step();
        chk("rst_ready", {31'h0, op_ready}, 32'h1);

        do_op(1'b0, 3'b000, 32'h0000_1003, 32'h0, 4'h0, 5'd5, 0, 0, 0, 32'h80FF_1234);
        do_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 4'h0, 5'd9, 0, 0, 0, 32'hBEEF_0001);
        do_op(1'b0, 3'b101, 32'h0000_2002, 32'h0, 4'h0, 5'd9, 3, 1, 0, 32'hBEEF_0001);
        do_op(1'b1, 3'b000, 32'h0000_0013, 32'hAB00_0000, 4'b1000, 5'd4, 0, 0, 0, 32'h0);
        do_op(1'b0, 3'b010, 32'h0000_0102, 32'h0, 4'h0, 5'd6, 0, 0, 0, 32'h0);
        do_op(1'b0, 3'b010, 32'h0000_0200, 32'h0, 4'h0, 5'd7, 2, 0, 1, 32'h1234_5678);
        do_op(1'b0, 3'b010, 32'h0000_0204, 32'h0, 4'h0, 5'd7, 1, 0, 2, 32'h1234_5678);
        do_op(1'b0, 3'b010, 32'h0000_0208, 32'h0, 4'h0, 5'd0, 0, 0, 0, 32'hCAFE_F00D);
        do_op(1'b1, 3'b011, 32'h0000_0300, 32'h5555_AAAA, 4'hF, 5'd1, 0, 0, 0, 32'h0);

        // Flush in IDLE blocks acceptance.
        op_valid = 1'b1; op_funct3 = 3'b010; op_addr = 32'h400; op_we = 1'b0; flush = 1'b1;
        #1;
        chk("flush_blocks_ready", {31'h0, op_ready}, 32'h0);
        step();
        op_valid = 1'b0; flush = 1'b0;
        chk("flush_no_accept", {31'h0, busy}, 32'h0);
        chk("flush_no_req", {31'h0, bus_req}, 32'h0);

        for (int i = 0; i < 250; i++) begin
            r  = $urandom_range(0, 9);
            fm = (r <= 6) ? 0 : (r - 6);
            do_op(1'($urandom), 3'($urandom), $urandom, $urandom, 4'($urandom), 5'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3), fm, $urandom);
        end

        // Reset while waiting for the response abandons the transaction.
        op_valid = 1'b1; op_we = 1'b0; op_funct3 = 3'b010; op_addr = 32'h0000_0040; op_rd = 5'd7;
        step();
        op_valid = 1'b0; bus_gnt = 1'b1;
        step();
        bus_gnt = 1'b0;
        chk("pre_rst_busy", {31'h0, busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_wait");
        step();
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        step();
        bus_rvalid = 1'b0;
        chk("rst_stray_we", {31'h0, reg_we}, 32'h0);
        chk("rst_stray_busy", {31'h0, busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
